// File: rtl/l2_cache_write_pkg.sv
// Shared widths, request op codes and the writeback entry layout for the L2 write stage.
package l2_cache_write_pkg;

   localparam int L2_ADDR_WIDTH       = 26;
   localparam int L2_SET_INDEX_WIDTH  = 5;
   localparam int L2_TAG_WIDTH        = L2_ADDR_WIDTH - L2_SET_INDEX_WIDTH;
   localparam int L2_WAY_WIDTH        = 2;
   localparam int L2_CACHE_ADDR_WIDTH = L2_WAY_WIDTH + L2_SET_INDEX_WIDTH;
   localparam int L2_LINE_WIDTH       = 512;
   localparam int L2_LINE_BYTES       = L2_LINE_WIDTH / 8;
   localparam int L2_WB_ENTRY_WIDTH   = L2_ADDR_WIDTH + L2_LINE_WIDTH;

   typedef enum logic [2:0] {
      L2REQ_LOAD       = 3'd0,
      L2REQ_STORE      = 3'd1,
      L2REQ_FLUSH      = 3'd2,
      L2REQ_INVALIDATE = 3'd3,
      L2REQ_LOAD_SYNC  = 3'd4,
      L2REQ_STORE_SYNC = 3'd5
   } l2req_op_t;

   typedef struct packed {
      logic [L2_ADDR_WIDTH-1:0] address;
      logic [L2_LINE_WIDTH-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/l2_writeback_queue.sv
// Small FIFO of dirty lines headed to system memory, presented with a valid/ready handshake.
module l2_writeback_queue
   import l2_cache_write_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic      clk,
   input  logic      reset_n,
   input  logic      push_i,
   input  wb_entry_t pushData_i,
   output logic      full_o,
   output logic      valid_o,
   input  logic      ready_i,
   output wb_entry_t popData_o
);

   localparam int PTR_W = $clog2(DEPTH);

   wb_entry_t        entries_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q;
   logic [PTR_W-1:0] rdPtr_q;
   logic [PTR_W:0]   count_q;
   logic             doPush;
   logic             doPop;

   assign full_o    = count_q == (PTR_W+1)'(DEPTH);
   assign valid_o   = count_q != '0;
   assign doPush    = push_i && !full_o;
   assign doPop     = valid_o && ready_i;
   assign popData_o = valid_o ? entries_q[rdPtr_q] : '0;

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
         if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
         if (doPush && !doPop)      count_q <= count_q + (PTR_W+1)'(1);
         else if (doPop && !doPush) count_q <= count_q - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) entries_q[wrPtr_q] <= pushData_i;
   end

   assert property (@(posedge clk) disable iff (!reset_n) !(push_i && full_o));

endmodule

// File: rtl/l2_cache_write.sv
// L2 write/update stage: merges store or fill data, writes the SRAM and queues dirty evictions.
// Define L2_WRITE_BYPASS_EN to forward the previous cycle's SRAM write into the base line.
module l2_cache_write
   import l2_cache_write_pkg::*;
#(
   parameter int WB_DEPTH = 4
)
(
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           stall_pipeline,
   input  logic                           rd_l2req_valid,
   input  logic [1:0]                     rd_l2req_core,
   input  logic [1:0]                     rd_l2req_unit,
   input  logic [1:0]                     rd_l2req_strand,
   input  logic [2:0]                     rd_l2req_op,
   input  logic [1:0]                     rd_l2req_way,
   input  logic [L2_ADDR_WIDTH-1:0]       rd_l2req_address,
   input  logic [L2_LINE_WIDTH-1:0]       rd_l2req_data,
   input  logic [L2_LINE_BYTES-1:0]       rd_l2req_mask,
   input  logic                           rd_has_sm_data,
   input  logic [L2_LINE_WIDTH-1:0]       rd_sm_data,
   input  logic [1:0]                     rd_sm_fill_l2_way,
   input  logic [1:0]                     rd_hit_l2_way,
   input  logic                           rd_cache_hit,
   input  logic [L2_LINE_WIDTH-1:0]       rd_cache_mem_result,
   input  logic [L2_TAG_WIDTH-1:0]        rd_old_l2_tag,
   input  logic                           rd_line_is_dirty,
   input  logic                           rd_store_sync_success,
   output logic                           wr_update_l2_data,
   output logic [L2_CACHE_ADDR_WIDTH-1:0] wr_cache_write_index,
   output logic [L2_LINE_WIDTH-1:0]       wr_update_data,
   output logic                           wr_l2req_valid,
   output logic [1:0]                     wr_l2req_core,
   output logic [1:0]                     wr_l2req_unit,
   output logic [1:0]                     wr_l2req_strand,
   output logic [2:0]                     wr_l2req_op,
   output logic [L2_ADDR_WIDTH-1:0]       wr_l2req_address,
   output logic [L2_LINE_WIDTH-1:0]       wr_data,
   output logic                           wr_store_sync_success,
   output logic                           wb_valid,
   input  logic                           wb_ready,
   output logic [L2_ADDR_WIDTH-1:0]       wb_address,
   output logic [L2_LINE_WIDTH-1:0]       wb_data,
   output logic                           wr_wb_full
);

   logic                           isStore;
   logic                           isStoreSync;
   logic                           isFlush;
   logic                           doMerge;
   logic                           writeEn_d;
   logic                           enqueue;
   logic [L2_SET_INDEX_WIDTH-1:0]  setIdx;
   logic [L2_CACHE_ADDR_WIDTH-1:0] writeIndex_d;
   logic [L2_LINE_WIDTH-1:0]       oldLine;
   logic [L2_LINE_WIDTH-1:0]       baseLine;
   logic [L2_LINE_WIDTH-1:0]       lineData_d;
   wb_entry_t                      wbPush;
   wb_entry_t                      wbHead;
   logic                           unusedWay;

   logic                           writeEn_q;
   logic [L2_CACHE_ADDR_WIDTH-1:0] writeIndex_q;
   logic [L2_LINE_WIDTH-1:0]       lineData_q;
   logic                           valid_q;
   logic [1:0]                     core_q;
   logic [1:0]                     unit_q;
   logic [1:0]                     strand_q;
   logic [2:0]                     op_q;
   logic [L2_ADDR_WIDTH-1:0]       address_q;
   logic                           syncSuccess_q;

   // The request's own way field is superseded by the directory's hit/fill way.
   assign unusedWay = ^rd_l2req_way;

   assign isStore      = rd_l2req_op == L2REQ_STORE;
   assign isStoreSync  = rd_l2req_op == L2REQ_STORE_SYNC;
   assign isFlush      = rd_l2req_op == L2REQ_FLUSH;
   assign doMerge      = isStore || (isStoreSync && rd_store_sync_success);
   assign setIdx       = rd_l2req_address[L2_SET_INDEX_WIDTH-1:0];
   assign writeIndex_d = {rd_cache_hit ? rd_hit_l2_way : rd_sm_fill_l2_way, setIdx};
   assign writeEn_d    = rd_l2req_valid && (rd_has_sm_data || (rd_cache_hit && doMerge));

`ifdef L2_WRITE_BYPASS_EN
   // The write leaving our registers this cycle is not yet reflected in the SRAM read data.
   assign oldLine = (writeEn_q && writeIndex_q == writeIndex_d) ? lineData_q : rd_cache_mem_result;
`else
   assign oldLine = rd_cache_mem_result;
`endif

   assign baseLine = rd_has_sm_data ? rd_sm_data : oldLine;

   always_comb begin
      lineData_d = baseLine;
      for (int i = 0; i < L2_LINE_BYTES; i++) begin
         if (doMerge && rd_l2req_mask[i]) lineData_d[i*8 +: 8] = rd_l2req_data[i*8 +: 8];
      end
   end

   assign enqueue = rd_l2req_valid && rd_line_is_dirty && !stall_pipeline
                    && (rd_has_sm_data || (isFlush && rd_cache_hit));
   assign wbPush.address = rd_has_sm_data ? {rd_old_l2_tag, setIdx} : rd_l2req_address;
   assign wbPush.data    = oldLine;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         writeEn_q     <= 1'b0;
         writeIndex_q  <= '0;
         lineData_q    <= '0;
         valid_q       <= 1'b0;
         core_q        <= '0;
         unit_q        <= '0;
         strand_q      <= '0;
         op_q          <= '0;
         address_q     <= '0;
         syncSuccess_q <= 1'b0;
      end else if (!stall_pipeline) begin
         writeEn_q     <= writeEn_d;
         writeIndex_q  <= writeIndex_d;
         lineData_q    <= lineData_d;
         valid_q       <= rd_l2req_valid;
         core_q        <= rd_l2req_core;
         unit_q        <= rd_l2req_unit;
         strand_q      <= rd_l2req_strand;
         op_q          <= rd_l2req_op;
         address_q     <= rd_l2req_address;
         syncSuccess_q <= rd_l2req_valid && isStoreSync && rd_store_sync_success;
      end
   end

   l2_writeback_queue #(.DEPTH(WB_DEPTH)) wbQueue (
      .clk        (clk),
      .reset_n    (reset_n),
      .push_i     (enqueue),
      .pushData_i (wbPush),
      .full_o     (wr_wb_full),
      .valid_o    (wb_valid),
      .ready_i    (wb_ready),
      .popData_o  (wbHead)
   );

   assign wb_address            = wbHead.address;
   assign wb_data               = wbHead.data;
   assign wr_update_l2_data     = writeEn_q;
   assign wr_cache_write_index  = writeIndex_q;
   assign wr_update_data        = lineData_q;
   assign wr_data               = lineData_q;
   assign wr_l2req_valid        = valid_q;
   assign wr_l2req_core         = core_q;
   assign wr_l2req_unit         = unit_q;
   assign wr_l2req_strand       = strand_q;
   assign wr_l2req_op           = op_q;
   assign wr_l2req_address      = address_q;
   assign wr_store_sync_success = syncSuccess_q;

endmodule

// File: tb/tb_l2_cache_write.sv
// Directed bench for l2_cache_write: merge, fill eviction, flush, full queue, stall and reset.
module tb_l2_cache_write;
   import l2_cache_write_pkg::*;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic         stall_pipeline;
   logic         forceStall = 1'b0;
   logic         autoStall = 1'b0;
   logic         rd_l2req_valid;
   logic [1:0]   rd_l2req_core, rd_l2req_unit, rd_l2req_strand, rd_l2req_way;
   logic [2:0]   rd_l2req_op;
   logic [25:0]  rd_l2req_address;
   logic [511:0] rd_l2req_data, rd_sm_data, rd_cache_mem_result;
   logic [63:0]  rd_l2req_mask;
   logic         rd_has_sm_data, rd_cache_hit, rd_line_is_dirty, rd_store_sync_success;
   logic [1:0]   rd_sm_fill_l2_way, rd_hit_l2_way;
   logic [20:0]  rd_old_l2_tag;
   logic         wr_update_l2_data, wr_l2req_valid, wr_store_sync_success;
   logic [6:0]   wr_cache_write_index;
   logic [511:0] wr_update_data, wr_data, wb_data;
   logic [1:0]   wr_l2req_core, wr_l2req_unit, wr_l2req_strand;
   logic [2:0]   wr_l2req_op;
   logic [25:0]  wr_l2req_address, wb_address;
   logic         wb_valid, wb_ready = 1'b0, wr_wb_full;

   int testCount = 0;
   int failCount = 0;

   always #5 clk = ~clk;

   // The arbiter behaviour: a full writeback queue stalls the pipeline.
   assign stall_pipeline = forceStall | (autoStall & wr_wb_full);

   l2_cache_write #(.WB_DEPTH(4)) dut (
      .clk(clk), .reset_n(reset_n), .stall_pipeline(stall_pipeline),
      .rd_l2req_valid(rd_l2req_valid), .rd_l2req_core(rd_l2req_core),
      .rd_l2req_unit(rd_l2req_unit), .rd_l2req_strand(rd_l2req_strand),
      .rd_l2req_op(rd_l2req_op), .rd_l2req_way(rd_l2req_way),
      .rd_l2req_address(rd_l2req_address), .rd_l2req_data(rd_l2req_data),
      .rd_l2req_mask(rd_l2req_mask), .rd_has_sm_data(rd_has_sm_data),
      .rd_sm_data(rd_sm_data), .rd_sm_fill_l2_way(rd_sm_fill_l2_way),
      .rd_hit_l2_way(rd_hit_l2_way), .rd_cache_hit(rd_cache_hit),
      .rd_cache_mem_result(rd_cache_mem_result), .rd_old_l2_tag(rd_old_l2_tag),
      .rd_line_is_dirty(rd_line_is_dirty), .rd_store_sync_success(rd_store_sync_success),
      .wr_update_l2_data(wr_update_l2_data), .wr_cache_write_index(wr_cache_write_index),
      .wr_update_data(wr_update_data), .wr_l2req_valid(wr_l2req_valid),
      .wr_l2req_core(wr_l2req_core), .wr_l2req_unit(wr_l2req_unit),
      .wr_l2req_strand(wr_l2req_strand), .wr_l2req_op(wr_l2req_op),
      .wr_l2req_address(wr_l2req_address), .wr_data(wr_data),
      .wr_store_sync_success(wr_store_sync_success), .wb_valid(wb_valid),
      .wb_ready(wb_ready), .wb_address(wb_address), .wb_data(wb_data),
      .wr_wb_full(wr_wb_full)
   );

   task automatic driveIdle();
      rd_l2req_valid = 1'b0; rd_l2req_core = '0; rd_l2req_unit = '0; rd_l2req_strand = '0;
      rd_l2req_op = '0; rd_l2req_way = '0; rd_l2req_address = '0; rd_l2req_data = '0;
      rd_l2req_mask = '0; rd_has_sm_data = 1'b0; rd_sm_data = '0; rd_sm_fill_l2_way = '0;
      rd_hit_l2_way = '0; rd_cache_hit = 1'b0; rd_cache_mem_result = '0; rd_old_l2_tag = '0;
      rd_line_is_dirty = 1'b0; rd_store_sync_success = 1'b0;
   endtask

   // Dirty fill: the line being replaced goes to the writeback queue.
   task automatic driveFill(input logic [20:0] oldTag, input logic [4:0] setIdx,
                            input logic [1:0] way, input logic [511:0] oldLine,
                            input logic [511:0] fillLine);
      driveIdle();
      rd_l2req_valid = 1'b1; rd_l2req_op = L2REQ_LOAD; rd_l2req_address = {21'h0F0F0, setIdx};
      rd_has_sm_data = 1'b1; rd_sm_data = fillLine; rd_sm_fill_l2_way = way;
      rd_cache_mem_result = oldLine; rd_old_l2_tag = oldTag; rd_line_is_dirty = 1'b1;
   endtask

   task automatic test_reset();
      driveIdle();
      #1 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      testCount++; if (wr_update_l2_data !== 1'b0) begin failCount++; $display("[TB] FAIL reset_update got %h want 0", wr_update_l2_data); end
      testCount++; if (wr_l2req_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid got %h want 0", wr_l2req_valid); end
      testCount++; if (wb_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_wb_valid got %h want 0", wb_valid); end
      testCount++; if (wr_wb_full !== 1'b0) begin failCount++; $display("[TB] FAIL reset_full got %h want 0", wr_wb_full); end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_store_hit();
      logic [511:0] expLine;
      expLine = {{63{8'hAA}}, 8'h55};
      driveIdle();
      rd_l2req_valid = 1'b1; rd_l2req_op = L2REQ_STORE; rd_l2req_core = 2'd1; rd_l2req_strand = 2'd3;
      rd_l2req_address = {21'h00123, 5'd5}; rd_l2req_data = {64{8'h55}}; rd_l2req_mask = 64'h1;
      rd_hit_l2_way = 2'd2; rd_cache_hit = 1'b1; rd_cache_mem_result = {64{8'hAA}};
      @(negedge clk);
      testCount++; if (wr_update_l2_data !== 1'b1) begin failCount++; $display("[TB] FAIL store_update got %h want 1", wr_update_l2_data); end
      testCount++; if (wr_cache_write_index !== 7'h45) begin failCount++; $display("[TB] FAIL store_index got %h want 45", wr_cache_write_index); end
      testCount++; if (wr_update_data !== expLine) begin failCount++; $display("[TB] FAIL store_line got %h want %h", wr_update_data, expLine); end
      testCount++; if (wr_data !== expLine) begin failCount++; $display("[TB] FAIL store_wr_data got %h want %h", wr_data, expLine); end
      testCount++; if ({wr_l2req_valid, wr_l2req_core, wr_l2req_strand, wr_l2req_op} !== {1'b1, 2'd1, 2'd3, 3'd1}) begin failCount++; $display("[TB] FAIL store_fwd got %b %h %h %h", wr_l2req_valid, wr_l2req_core, wr_l2req_strand, wr_l2req_op); end
      testCount++; if (wr_l2req_address !== {21'h00123, 5'd5}) begin failCount++; $display("[TB] FAIL store_addr got %h want %h", wr_l2req_address, {21'h00123, 5'd5}); end
      testCount++; if (wb_valid !== 1'b0) begin failCount++; $display("[TB] FAIL store_no_enqueue got %h want 0", wb_valid); end
      driveIdle();
      @(negedge clk);
   endtask

   task automatic test_store_sync();
      logic [511:0] expLine;
      expLine = {8'h55, {62{8'h11}}, 8'h55};
      driveIdle();
      rd_l2req_valid = 1'b1; rd_l2req_op = L2REQ_STORE_SYNC; rd_l2req_address = {21'h00044, 5'd7};
      rd_l2req_data = {64{8'h55}}; rd_l2req_mask = 64'h8000_0000_0000_0001;
      rd_hit_l2_way = 2'd1; rd_cache_hit = 1'b1; rd_cache_mem_result = {64{8'h11}};
      rd_store_sync_success = 1'b0;
      @(negedge clk);
      testCount++; if (wr_update_l2_data !== 1'b0) begin failCount++; $display("[TB] FAIL sync_fail_update got %h want 0", wr_update_l2_data); end
      testCount++; if (wr_store_sync_success !== 1'b0) begin failCount++; $display("[TB] FAIL sync_fail_flag got %h want 0", wr_store_sync_success); end
      testCount++; if (wr_data !== {64{8'h11}}) begin failCount++; $display("[TB] FAIL sync_fail_data got %h want %h", wr_data, {64{8'h11}}); end
      rd_store_sync_success = 1'b1;
      @(negedge clk);
      testCount++; if (wr_update_l2_data !== 1'b1) begin failCount++; $display("[TB] FAIL sync_ok_update got %h want 1", wr_update_l2_data); end
      testCount++; if (wr_store_sync_success !== 1'b1) begin failCount++; $display("[TB] FAIL sync_ok_flag got %h want 1", wr_store_sync_success); end
      testCount++; if (wr_data !== expLine) begin failCount++; $display("[TB] FAIL sync_ok_data got %h want %h", wr_data, expLine); end
      driveIdle();
      rd_l2req_valid = 1'b1; rd_l2req_op = L2REQ_LOAD; rd_cache_hit = 1'b1; rd_line_is_dirty = 1'b1;
      rd_l2req_mask = '1; rd_l2req_data = {64{8'h99}}; rd_cache_mem_result = {64{8'h22}};
      @(negedge clk);
      testCount++; if (wr_update_l2_data !== 1'b0) begin failCount++; $display("[TB] FAIL load_update got %h want 0", wr_update_l2_data); end
      testCount++; if (wr_data !== {64{8'h22}}) begin failCount++; $display("[TB] FAIL load_data got %h want %h", wr_data, {64{8'h22}}); end
      testCount++; if (wb_valid !== 1'b0) begin failCount++; $display("[TB] FAIL load_no_enqueue got %h want 0", wb_valid); end
      driveIdle();
      @(negedge clk);
   endtask

   task automatic test_fill_dirty();
      driveFill(21'h1ABCD, 5'd9, 2'd1, {64{8'hAA}}, {64{8'h3C}});
      @(negedge clk);
      testCount++; if (wr_update_l2_data !== 1'b1) begin failCount++; $display("[TB] FAIL fill_update got %h want 1", wr_update_l2_data); end
      testCount++; if (wr_cache_write_index !== 7'h29) begin failCount++; $display("[TB] FAIL fill_index got %h want 29", wr_cache_write_index); end
      testCount++; if (wr_update_data !== {64{8'h3C}}) begin failCount++; $display("[TB] FAIL fill_line got %h want %h", wr_update_data, {64{8'h3C}}); end
      testCount++; if (wb_valid !== 1'b1) begin failCount++; $display("[TB] FAIL fill_wb_valid got %h want 1", wb_valid); end
      testCount++; if (wb_address !== {21'h1ABCD, 5'd9}) begin failCount++; $display("[TB] FAIL fill_wb_addr got %h want %h", wb_address, {21'h1ABCD, 5'd9}); end
      testCount++; if (wb_data !== {64{8'hAA}}) begin failCount++; $display("[TB] FAIL fill_wb_data got %h want %h", wb_data, {64{8'hAA}}); end
      driveIdle();
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
      testCount++; if (wb_valid !== 1'b0) begin failCount++; $display("[TB] FAIL fill_drain got %h want 0", wb_valid); end
   endtask

   task automatic test_flush();
      driveIdle();
      rd_l2req_valid = 1'b1; rd_l2req_op = L2REQ_FLUSH; rd_l2req_address = {21'h0BEEF, 5'd3};
      rd_hit_l2_way = 2'd3; rd_cache_hit = 1'b1; rd_line_is_dirty = 1'b1; rd_cache_mem_result = {64{8'h77}};
      @(negedge clk);
      driveIdle();
      testCount++; if (wr_update_l2_data !== 1'b0) begin failCount++; $display("[TB] FAIL flush_update got %h want 0", wr_update_l2_data); end
      testCount++; if (wb_address !== {21'h0BEEF, 5'd3} || wb_valid !== 1'b1) begin failCount++; $display("[TB] FAIL flush_wb_addr got %h valid %h want %h", wb_address, wb_valid, {21'h0BEEF, 5'd3}); end
      testCount++; if (wb_data !== {64{8'h77}}) begin failCount++; $display("[TB] FAIL flush_wb_data got %h want %h", wb_data, {64{8'h77}}); end
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
   endtask

   task automatic test_queue_full();
      logic [25:0]  expAddr [5];
      logic [511:0] expData [5];
      logic [7:0]   fillByte;
      logic         pending, accept;
      for (int i = 0; i < 5; i++) begin
         fillByte = 8'(8'h10 + i);
         expAddr[i] = {21'(21'h100 + i), 5'(i + 1)};
         expData[i] = {64{fillByte}};
      end
      autoStall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         driveFill(expAddr[i][25:5], expAddr[i][4:0], 2'd0, expData[i], {64{8'hEE}});
         @(negedge clk);
      end
      driveFill(expAddr[4][25:5], expAddr[4][4:0], 2'd0, expData[4], {64{8'hEE}});
      testCount++; if (wr_wb_full !== 1'b1) begin failCount++; $display("[TB] FAIL full_after4 got %h want 1", wr_wb_full); end
      repeat (3) @(negedge clk);
      testCount++; if (wr_wb_full !== 1'b1) begin failCount++; $display("[TB] FAIL full_held got %h want 1", wr_wb_full); end
      testCount++; if (wb_address !== expAddr[0]) begin failCount++; $display("[TB] FAIL full_head_stable got %h want %h", wb_address, expAddr[0]); end
      pending = 1'b1;
      wb_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         testCount++; if (wb_valid !== 1'b1 || wb_address !== expAddr[k]) begin failCount++; $display("[TB] FAIL order_addr%0d got %h valid %h want %h", k, wb_address, wb_valid, expAddr[k]); end
         testCount++; if (wb_data !== expData[k]) begin failCount++; $display("[TB] FAIL order_data%0d got %h want %h", k, wb_data, expData[k]); end
         accept = pending && !stall_pipeline;
         @(negedge clk);
         if (accept) begin
            driveIdle();
            pending = 1'b0;
         end
      end
      testCount++; if (wb_valid !== 1'b0 || pending !== 1'b0) begin failCount++; $display("[TB] FAIL full_drained got valid %h pending %h want 0 0", wb_valid, pending); end
      driveIdle();
      wb_ready = 1'b0;
      autoStall = 1'b0;
   endtask

   task automatic test_stall();
      driveFill(21'h0AAAA, 5'd12, 2'd0, {64{8'hA1}}, {64{8'hF1}});
      @(negedge clk);
      testCount++; if (wr_update_l2_data !== 1'b1 || wr_cache_write_index !== 7'h0C) begin failCount++; $display("[TB] FAIL stall_first got %h idx %h want 1 0c", wr_update_l2_data, wr_cache_write_index); end
      forceStall = 1'b1;
      driveFill(21'h0BBBB, 5'd13, 2'd3, {64{8'hB2}}, {64{8'hF2}});
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         testCount++; if (wr_cache_write_index !== 7'h0C || wr_update_data !== {64{8'hF1}}) begin failCount++; $display("[TB] FAIL stall_frozen%0d got idx %h line %h want 0c", c, wr_cache_write_index, wr_update_data); end
         testCount++; if (wr_l2req_address !== {21'h0F0F0, 5'd12} || wr_update_l2_data !== 1'b1) begin failCount++; $display("[TB] FAIL stall_addr%0d got %h en %h want %h", c, wr_l2req_address, wr_update_l2_data, {21'h0F0F0, 5'd12}); end
      end
      forceStall = 1'b0;
      @(negedge clk);
      driveIdle();
      testCount++; if (wr_cache_write_index !== 7'h6D || wr_update_data !== {64{8'hF2}}) begin failCount++; $display("[TB] FAIL stall_release got idx %h line %h want 6d", wr_cache_write_index, wr_update_data); end
      wb_ready = 1'b1;
      testCount++; if (wb_address !== {21'h0AAAA, 5'd12}) begin failCount++; $display("[TB] FAIL stall_q0 got %h want %h", wb_address, {21'h0AAAA, 5'd12}); end
      @(negedge clk);
      testCount++; if (wb_address !== {21'h0BBBB, 5'd13} || wb_valid !== 1'b1) begin failCount++; $display("[TB] FAIL stall_q1 got %h valid %h want %h", wb_address, wb_valid, {21'h0BBBB, 5'd13}); end
      @(negedge clk);
      testCount++; if (wb_valid !== 1'b0) begin failCount++; $display("[TB] FAIL stall_single_enqueue got valid %h want 0", wb_valid); end
      wb_ready = 1'b0;
   endtask

   task automatic test_reset_mid_queue();
      driveFill(21'h00011, 5'd1, 2'd0, {64{8'h01}}, {64{8'h00}});
      @(negedge clk);
      driveFill(21'h00022, 5'd2, 2'd0, {64{8'h02}}, {64{8'h00}});
      @(negedge clk);
      driveIdle();
      testCount++; if (wb_valid !== 1'b1) begin failCount++; $display("[TB] FAIL midq_queued got %h want 1", wb_valid); end
      #1 reset_n = 1'b0;
      #1;
      testCount++; if (wb_valid !== 1'b0 || wr_wb_full !== 1'b0) begin failCount++; $display("[TB] FAIL midq_reset_wb got valid %h full %h want 0 0", wb_valid, wr_wb_full); end
      testCount++; if (wr_l2req_valid !== 1'b0 || wr_update_l2_data !== 1'b0) begin failCount++; $display("[TB] FAIL midq_reset_out got %h %h want 0 0", wr_l2req_valid, wr_update_l2_data); end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      driveFill(21'h00033, 5'd3, 2'd0, {64{8'h03}}, {64{8'h00}});
      @(negedge clk);
      driveIdle();
      testCount++; if (wb_valid !== 1'b1 || wb_address !== {21'h00033, 5'd3}) begin failCount++; $display("[TB] FAIL midq_new_head got %h valid %h want %h", wb_address, wb_valid, {21'h00033, 5'd3}); end
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
      testCount++; if (wb_valid !== 1'b0) begin failCount++; $display("[TB] FAIL midq_one_entry got %h want 0", wb_valid); end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      driveIdle();
      test_reset();
      test_store_hit();
      test_store_sync();
      test_fill_dirty();
      test_flush();
      test_queue_full();
      test_stall();
      test_reset_mid_queue();
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
